// File: rtl/pulse_decoder_seq.sv
// Queued binary-to-one-hot decoder: codes arrive over valid/ready, wait in a
// small FIFO, and are replayed as fixed-width one-hot pulses separated by a gap.
module pulse_decoder_seq #(
  parameter int unsigned N          = 3,
  parameter int unsigned PULSE_LEN  = 4,
  parameter int unsigned GAP_LEN    = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [N-1:0]                  in_code,
  output logic                          in_ready,
  output logic [(1<<N)-1:0]             y,
  output logic                          done,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int unsigned M    = 1 << N;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LW   = PW + 1;
  localparam int unsigned MAXL = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int unsigned TW   = (MAXL > 1) ? $clog2(MAXL + 1) : 1;

  localparam logic [TW-1:0] PULSE_T = TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] GAP_T   = (GAP_LEN > 0) ? TW'(GAP_LEN - 1) : '0;
  localparam logic [LW-1:0] FULL_L  = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  function automatic logic [M-1:0] decode(input logic [N-1:0] code);
    logic [M-1:0] oh;
    oh       = '0;
    oh[code] = 1'b1;
    return oh;
  endfunction

  logic [N-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic          push;
  logic          pop;
  logic [N-1:0]  head;

  state_t        state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [M-1:0]  y_n;
  logic          done_n;

  // Ready depends on the stored level only, so a pop never frees a slot in the same cycle.
  assign in_ready = (level != FULL_L);
  assign push     = in_valid && in_ready;
  assign head     = mem[rptr];
  assign busy     = (state != IDLE) || (level != '0);

  // Storage holds data only; emptiness is tracked by level, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wptr] <= in_code;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push) begin
        wptr <= wptr + 1'b1;
      end
      if (pop) begin
        rptr <= rptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    y_n     = y;
    done_n  = 1'b0;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        y_n = '0;
        if (level != '0) begin
          pop     = 1'b1;
          y_n     = decode(head);
          timer_n = PULSE_T;
          state_n = PULSE;
        end
      end
      PULSE: begin
        if (timer == '0) begin
          y_n    = '0;
          done_n = 1'b1;
          if (GAP_LEN > 0) begin
            timer_n = GAP_T;
            state_n = GAP;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      GAP: begin
        y_n = '0;
        if (timer == '0) begin
          state_n = IDLE;
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      default: begin
        y_n     = '0;
        state_n = IDLE;
      end
    endcase
  end

  // y and done come straight from flops so downstream strobes are glitch-free.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      y     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      y     <= y_n;
      done  <= done_n;
    end
  end

endmodule

// File: tb/tb_pulse_decoder_seq.sv
// Directed bench for pulse_decoder_seq: default build plus a PULSE_LEN=1, GAP_LEN=0 build.
module tb_pulse_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_valid6;
  logic [2:0] in_code, in_code6;
  logic       in_ready, in_ready6;
  logic [7:0] y, y6;
  logic       done, done6;
  logic       busy, busy6;
  logic [2:0] level, level6;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pulse_decoder_seq #(.N(3), .PULSE_LEN(4), .GAP_LEN(1), .FIFO_DEPTH(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .y(y), .done(done), .busy(busy), .level(level)
  );

  pulse_decoder_seq #(.N(3), .PULSE_LEN(1), .GAP_LEN(0), .FIFO_DEPTH(4)) u_dut6 (
    .clk(clk), .rst(rst), .in_valid(in_valid6), .in_code(in_code6),
    .in_ready(in_ready6), .y(y6), .done(done6), .busy(busy6), .level(level6)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called on a cycle where y should already show e; checks n high cycles then the done cycle.
  task automatic exp_pulse(input logic [31:0] e, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      chk({tag, "_y"}, 32'(y), e);
      tick();
    end
    chk({tag, "_end_y"}, 32'(y), 0);
    chk({tag, "_done"}, 32'(done), 1);
  endtask

  // From a done cycle: one idle zero cycle, then the next pulse with the given remaining level.
  task automatic next_pulse(input logic [31:0] e, input int lvl, input string tag);
    tick();
    chk({tag, "_gap_y"}, 32'(y), 0);
    chk({tag, "_gap_done"}, 32'(done), 0);
    tick();
    chk({tag, "_level"}, 32'(level), 32'(lvl));
    exp_pulse(e, 4, tag);
  endtask

  initial begin
    int c0 [5];
    int c1 [5];
    logic [7:0] acc;
    c0 = '{1, 3, 7, 0, 5};
    c1 = '{6, 4, 2, 5, 3};

    rst = 1'b1; in_valid = 1'b0; in_code = '0; in_valid6 = 1'b0; in_code6 = '0;
    tick(); tick();
    chk("rst_y", 32'(y), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_y6", 32'(y6), 0);
    rst = 1'b0;
    tick();

    // Test 1: single code 5
    in_valid = 1'b1; in_code = 3'd5;
    tick();
    in_valid = 1'b0;
    chk("t1_level_push", 32'(level), 1);
    chk("t1_y_latency", 32'(y), 0);
    chk("t1_busy", 32'(busy), 1);
    tick();
    chk("t1_level_pop", 32'(level), 0);
    exp_pulse(32'h20, 4, "t1");
    chk("t1_busy_gap", 32'(busy), 1);
    tick();
    chk("t1_done_once", 32'(done), 0);
    chk("t1_busy_idle", 32'(busy), 0);

    // Test 2: code 3 pulsing while 7,0,2,6 fill the FIFO
    in_valid = 1'b1; in_code = 3'd3;
    tick();
    in_code = 3'd7;
    tick();
    chk("t2_first_y", 32'(y), 32'h08);
    in_code = 3'd0;
    tick();
    in_code = 3'd2;
    tick();
    in_code = 3'd6;
    tick();
    in_valid = 1'b0;
    chk("t2_level_full", 32'(level), 4);
    chk("t2_ready_low", 32'(in_ready), 0);
    chk("t2_first_y4", 32'(y), 32'h08);
    tick();
    chk("t2_first_done", 32'(done), 1);
    next_pulse(32'h80, 3, "t2_p7");
    next_pulse(32'h01, 2, "t2_p0");
    next_pulse(32'h04, 1, "t2_p2");
    next_pulse(32'h40, 0, "t2_p6");
    tick();
    chk("t2_busy_end", 32'(busy), 0);

    // Test 3: full FIFO with a 5th code held on in_valid
    in_valid = 1'b1; in_code = 3'd1;
    tick();
    in_code = 3'd2;
    tick();
    in_code = 3'd3;
    tick();
    in_code = 3'd4;
    tick();
    in_code = 3'd5;
    tick();
    chk("t3_level_full", 32'(level), 4);
    chk("t3_ready_low", 32'(in_ready), 0);
    chk("t3_y_code1", 32'(y), 32'h02);
    in_code = 3'd6;
    tick();
    chk("t3_hold_level_a", 32'(level), 4);
    chk("t3_done_code1", 32'(done), 1);
    tick();
    chk("t3_hold_level_b", 32'(level), 4);
    tick();
    chk("t3_pop_level", 32'(level), 3);
    chk("t3_pop_ready", 32'(in_ready), 1);
    chk("t3_pop_y", 32'(y), 32'h04);
    tick();
    in_valid = 1'b0;
    chk("t3_accept_level", 32'(level), 4);
    exp_pulse(32'h04, 3, "t3_p2");
    next_pulse(32'h08, 3, "t3_p3");
    next_pulse(32'h10, 2, "t3_p4");
    next_pulse(32'h20, 1, "t3_p5");
    next_pulse(32'h40, 0, "t3_p6");
    tick();
    chk("t3_busy_end", 32'(busy), 0);

    // Test 4: push on the IDLE pop edge, 10 codes across pointer wraps
    for (int j = 0; j < 5; j++) begin
      in_valid = 1'b1; in_code = 3'(c0[j]);
      tick();
      chk("t4_level_a", 32'(level), 1);
      in_code = 3'(c1[j]);
      tick();
      in_valid = 1'b0;
      chk("t4_level_same", 32'(level), 1);
      exp_pulse(32'(1) << c0[j], 4, "t4_first");
      next_pulse(32'(1) << c1[j], 0, "t4_second");
      tick();
      chk("t4_busy_end", 32'(busy), 0);
    end

    // Test 5: async reset in the 2nd cycle of a pulse with 2 codes queued
    in_valid = 1'b1; in_code = 3'd1;
    tick();
    in_code = 3'd2;
    tick();
    in_code = 3'd3;
    tick();
    in_valid = 1'b0;
    chk("t5_pre_level", 32'(level), 2);
    chk("t5_pre_y", 32'(y), 32'h02);
    rst = 1'b1;
    #1;
    chk("t5_rst_y", 32'(y), 0);
    chk("t5_rst_level", 32'(level), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 12; i++) begin
      tick();
      acc = acc | y;
    end
    chk("t5_no_pulses", 32'(acc), 0);
    chk("t5_level_after", 32'(level), 0);

    // Test 6: PULSE_LEN=1, GAP_LEN=0 build
    in_valid6 = 1'b1; in_code6 = 3'd2;
    tick();
    in_code6 = 3'd5;
    tick();
    in_valid6 = 1'b0;
    chk("t6_p1_y", 32'(y6), 32'h04);
    chk("t6_p1_level", 32'(level6), 1);
    tick();
    chk("t6_gap_y", 32'(y6), 0);
    chk("t6_gap_done", 32'(done6), 1);
    tick();
    chk("t6_p2_y", 32'(y6), 32'h20);
    chk("t6_p2_done", 32'(done6), 0);
    tick();
    chk("t6_end_y", 32'(y6), 0);
    chk("t6_end_done", 32'(done6), 1);
    tick();
    chk("t6_idle_done", 32'(done6), 0);
    chk("t6_idle_busy", 32'(busy6), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
